// File: rtl/swervolf_wbm_pkg.sv
// Shared types and constants for the SweRVolf Wishbone initiator.
package swervolf_wbm_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/swervolf_wbm_timer.sv
// Wait-cycle counter that flags the bus cycle in which the ack wait reaches LIMIT.
module swervolf_wbm_timer
  import swervolf_wbm_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  // High in the wait cycle whose increment would bring the count to LIMIT.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/swervolf_wb_initiator.sv
// Single-outstanding classic Wishbone initiator: command in, bus cycle with
// ack timeout, response out.
module swervolf_wb_initiator
  import swervolf_wbm_pkg::*;
#(
  parameter int unsigned ADR_WIDTH      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [ADR_WIDTH-1:0] i_cmd_adr,
  input  logic [31:0]          i_cmd_dat,
  input  logic [3:0]           i_cmd_sel,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [31:0]          o_rsp_rdt,
  output logic                 o_rsp_err,
  output logic [ADR_WIDTH-1:0] o_wb_adr,
  output logic [31:0]          o_wb_dat,
  output logic [3:0]           o_wb_sel,
  output logic                 o_wb_we,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  input  logic [31:0]          i_wb_rdt,
  input  logic                 i_wb_ack
);

  wbm_state_e state;
  logic       timer_expired;

  assign o_cmd_ready = (state == IDLE);

  // Counter is held clear while idle, so it starts from zero on BUS entry.
  swervolf_wbm_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (state == IDLE),
    .enable  ((state == BUS) && !i_wb_ack),
    .expired (timer_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_wb_sel    <= '0;
      o_wb_we     <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdt   <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_wb_adr <= i_cmd_adr;
            o_wb_dat <= i_cmd_dat;
            o_wb_sel <= i_cmd_sel;
            o_wb_we  <= i_cmd_we;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            state    <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (i_wb_ack) begin
            o_rsp_rdt   <= o_wb_we ? 32'd0 : i_wb_rdt;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            state       <= RESP;
          end else if (timer_expired) begin
            o_rsp_rdt   <= 32'd0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swervolf_wb_initiator.sv
// Self-checking bench: transaction-level model of the initiator timing plus
// directed commands against a configurable-latency Wishbone responder.
module tb_swervolf_wb_initiator;

  localparam int unsigned AW = 6;
  localparam int          TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [31:0]   cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_ready = 1'b0;
  logic [31:0]   wb_rdt = '0;
  logic          wb_ack = 1'b0;
  logic          o_cmd_ready, o_rsp_valid, o_rsp_err;
  logic [31:0]   o_rsp_rdt, o_wb_dat;
  logic [AW-1:0] o_wb_adr;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we, o_wb_cyc, o_wb_stb;

  swervolf_wb_initiator #(
    .ADR_WIDTH      (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_we    (cmd_we),
    .i_cmd_adr   (cmd_adr),
    .i_cmd_dat   (cmd_dat),
    .i_cmd_sel   (cmd_sel),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdt   (o_rsp_rdt),
    .o_rsp_err   (o_rsp_err),
    .o_wb_adr    (o_wb_adr),
    .o_wb_dat    (o_wb_dat),
    .o_wb_sel    (o_wb_sel),
    .o_wb_we     (o_wb_we),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .i_wb_rdt    (wb_rdt),
    .i_wb_ack    (wb_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Responder: acks in the resp_d-th cycle of cyc (0 = never); spur drives ack outside cyc.
  logic [31:0] rd_data [16];
  int   resp_d = 2;
  logic spur = 1'b0;
  int   rcnt = 0;

  always @(negedge clk) begin
    if (o_wb_cyc) begin
      rcnt++;
      wb_ack = (resp_d != 0) && (rcnt == resp_d);
      wb_rdt = wb_ack ? rd_data[o_wb_adr[5:2]] : 32'hBAD0BAD0;
    end else begin
      rcnt   = 0;
      wb_ack = spur;
      wb_rdt = 32'hBAD0BAD0;
    end
  end

  // Transaction model: accept at cycle a, cyc over a+1..a+len, response from a+len+1.
  logic          pending = 1'b0;
  int            acc_n = 0, exp_len = 0, cyc_rise = -1, val_rise = -1;
  logic          exp_we, exp_err, last_err = 1'b0;
  logic [AW-1:0] exp_adr;
  logic [31:0]   exp_dat, exp_rdt, last_rdt = '0;
  logic [3:0]    exp_sel;
  int            acc_q[$];

  always @(negedge clk) begin
    logic in_bus, in_rsp, late;
    if (rst) begin
      chk("rst_cyc", 32'(o_wb_cyc), 0);
      chk("rst_stb", 32'(o_wb_stb), 0);
      chk("rst_we", 32'(o_wb_we), 0);
      chk("rst_adr", 32'(o_wb_adr), 0);
      chk("rst_dat", o_wb_dat, 0);
      chk("rst_sel", 32'(o_wb_sel), 0);
      chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
      chk("rst_rdt", o_rsp_rdt, 0);
      chk("rst_err", 32'(o_rsp_err), 0);
      chk("rst_cmd_ready", 32'(o_cmd_ready), 1);
      pending  = 1'b0;
      last_rdt = '0;
      last_err = 1'b0;
    end else begin
      in_bus = pending && (cyc_n >= acc_n + 1) && (cyc_n <= acc_n + exp_len);
      in_rsp = pending && (cyc_n > acc_n + exp_len);
      chk("cmd_ready", 32'(o_cmd_ready), 32'(!pending));
      chk("wb_cyc", 32'(o_wb_cyc), 32'(in_bus));
      chk("wb_stb", 32'(o_wb_stb), 32'(in_bus));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(in_rsp));
      chk("rsp_rdt", o_rsp_rdt, in_rsp ? exp_rdt : last_rdt);
      chk("rsp_err", 32'(o_rsp_err), in_rsp ? 32'(exp_err) : 32'(last_err));
      if (in_bus) begin
        chk("wb_adr", 32'(o_wb_adr), 32'(exp_adr));
        chk("wb_dat", o_wb_dat, exp_dat);
        chk("wb_sel", 32'(o_wb_sel), 32'(exp_sel));
        chk("wb_we", 32'(o_wb_we), 32'(exp_we));
      end
      if (o_wb_cyc && cyc_rise < 0) cyc_rise = cyc_n;
      if (o_rsp_valid && val_rise < 0) val_rise = cyc_n;
      if (in_rsp && rsp_ready) begin
        pending  = 1'b0;
        last_rdt = exp_rdt;
        last_err = exp_err;
      end else if (!pending && cmd_valid && o_cmd_ready) begin
        late     = (resp_d == 0) || (resp_d > TO);
        pending  = 1'b1;
        acc_n    = cyc_n;
        exp_len  = late ? TO : resp_d;
        exp_err  = late;
        exp_we   = cmd_we;
        exp_adr  = cmd_adr;
        exp_dat  = cmd_dat;
        exp_sel  = cmd_sel;
        exp_rdt  = (late || cmd_we) ? 32'd0 : rd_data[cmd_adr[5:2]];
        cyc_rise = -1;
        val_rise = -1;
        acc_q.push_back(cyc_n);
      end
    end
  end

  task automatic offer(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    n = 0;
    @(negedge clk);
    while (!o_cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!o_cmd_ready) chk("accept_wait", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int d, input int hold,
                         output logic [31:0] rdt, output logic err,
                         output int cyc_lat, output int val_lat);
    int n;
    resp_d = d;
    offer(we, adr, dat, sel);
    n = 0;
    while (!o_rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!o_rsp_valid) chk("rsp_wait", 0, 1);
    #1;
    rdt     = o_rsp_rdt;
    err     = o_rsp_err;
    cyc_lat = cyc_rise - acc_n;
    val_lat = val_rise - acc_n;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rdt;
    logic        err;
    int          cl, vl, n;

    for (int i = 0; i < 16; i++) rd_data[i] = 32'hC0DE0000 | 32'(i);
    rd_data[1] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Read from a registered-ack responder.
    run_cmd(1'b0, 6'h04, 32'h0, 4'hF, 2, 0, rdt, err, cl, vl);
    chk("rd_cyc_lat", 32'(cl), 1);
    chk("rd_val_lat", 32'(vl), 3);
    chk("rd_rdt", rdt, 32'hDEADBEEF);
    chk("rd_err", 32'(err), 0);

    // Write returns zero data.
    run_cmd(1'b1, 6'h3C, 32'h12345678, 4'hF, 2, 0, rdt, err, cl, vl);
    chk("wr_rdt", rdt, 32'h0);
    chk("wr_err", 32'(err), 0);
    chk("wr_val_lat", 32'(vl), 3);

    // Responder never acks.
    run_cmd(1'b0, 6'h08, 32'h0, 4'hF, 0, 0, rdt, err, cl, vl);
    chk("to_err", 32'(err), 1);
    chk("to_rdt", rdt, 32'h0);
    chk("to_val_lat", 32'(vl), 32'(TO + 1));
    run_cmd(1'b0, 6'h08, 32'h0, 4'h3, 3, 0, rdt, err, cl, vl);
    chk("after_to_rdt", rdt, 32'hC0DE0002);
    chk("after_to_err", 32'(err), 0);
    chk("after_to_val_lat", 32'(vl), 4);

    // Ack exactly on the last allowed wait cycle, response held 5 cycles.
    run_cmd(1'b0, 6'h10, 32'h0, 4'hF, TO, 5, rdt, err, cl, vl);
    chk("edge_err", 32'(err), 0);
    chk("edge_rdt", rdt, 32'hC0DE0004);
    chk("edge_val_lat", 32'(vl), 32'(TO + 1));

    // Ack one cycle too late.
    run_cmd(1'b0, 6'h14, 32'h0, 4'hF, TO + 1, 0, rdt, err, cl, vl);
    chk("late_err", 32'(err), 1);
    chk("late_rdt", rdt, 32'h0);

    // Back-to-back reads with ready held high.
    resp_d = 2;
    acc_q.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 6'h0C; cmd_sel = 4'hF;
    repeat (13) @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while ((!o_cmd_ready || o_rsp_valid) && n < 50) begin @(negedge clk); n++; end
    chk("tput_drain", 32'(o_cmd_ready), 1);
    @(posedge clk); #1 rsp_ready = 1'b0;
    chk("tput_count", 32'(acc_q.size() >= 3), 1);
    for (int i = 0; i + 1 < acc_q.size(); i++)
      chk("tput_gap", 32'(acc_q[i+1] - acc_q[i]), 4);

    // Reset during BUS aborts, next command works.
    resp_d = 0;
    offer(1'b0, 6'h04, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    reset_pulse();
    repeat (2) @(negedge clk);
    chk("rst_bus_no_rsp", 32'(o_rsp_valid), 0);
    run_cmd(1'b0, 6'h04, 32'h0, 4'hF, 2, 0, rdt, err, cl, vl);
    chk("post_rst_rdt", rdt, 32'hDEADBEEF);
    chk("post_rst_lat", 32'(vl), 3);

    // Reset during RESP aborts the pending response.
    resp_d = 2;
    offer(1'b0, 6'h18, 32'h0, 4'hF);
    n = 0;
    while (!o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("resp_reached", 32'(o_rsp_valid), 1);
    reset_pulse();
    @(negedge clk);
    chk("rst_resp_drop", 32'(o_rsp_valid), 0);
    run_cmd(1'b0, 6'h18, 32'h0, 4'hF, 2, 0, rdt, err, cl, vl);
    chk("post_rst2_rdt", rdt, 32'hC0DE0006);

    // Spurious acks in IDLE and RESP are ignored.
    spur = 1'b1;
    repeat (4) @(posedge clk);
    run_cmd(1'b0, 6'h0C, 32'h0, 4'hF, 2, 3, rdt, err, cl, vl);
    chk("spur_rdt", rdt, 32'hC0DE0003);
    chk("spur_lat", 32'(vl), 3);
    repeat (5) @(posedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_rdt", o_rsp_rdt, 32'hC0DE0003);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
